// File: rtl/vec_mem_ctrl.sv
// Vector load/store initiator for the 8-bit x 64-entry data RAM.
// Moves LANES elements between the vector datapath and consecutive RAM addresses, one per cycle.
module vec_mem_ctrl #(
  parameter int LANES   = 4,
  parameter int RAM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op,
  input  logic [5:0]         base_addr,
  input  logic [8*LANES-1:0] vec_in,
  output logic               busy,
  output logic               done,
  output logic [8*LANES-1:0] vec_out,
  output logic [7:0]         ram_data,
  output logic [5:0]         ram_read_addr,
  output logic [5:0]         ram_write_addr,
  output logic               ram_write_enable,
  input  logic [7:0]         ram_q
);

  localparam int CW = $clog2(LANES + RAM_LAT + 2) + 1;

  typedef enum logic [2:0] {IDLE, STORE, LOAD_ISSUE, LOAD_DRAIN, DONE} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      cyc, cyc_next;
  logic [5:0]         base_r, base_next;
  logic [8*LANES-1:0] vec_r, vec_next;
  logic [8*LANES-1:0] shadow, shadow_next;
  logic [8*LANES-1:0] vec_out_next;
  logic [7:0]         ram_data_next;
  logic [5:0]         rd_addr_next, wr_addr_next;
  logic               busy_next, done_next, we_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cyc              <= '0;
      base_r           <= '0;
      vec_r            <= '0;
      shadow           <= '0;
      vec_out          <= '0;
      ram_data         <= '0;
      ram_read_addr    <= '0;
      ram_write_addr   <= '0;
      ram_write_enable <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      state            <= state_next;
      cyc              <= cyc_next;
      base_r           <= base_next;
      vec_r            <= vec_next;
      shadow           <= shadow_next;
      vec_out          <= vec_out_next;
      ram_data         <= ram_data_next;
      ram_read_addr    <= rd_addr_next;
      ram_write_addr   <= wr_addr_next;
      ram_write_enable <= we_next;
      busy             <= busy_next;
      done             <= done_next;
    end
  end

  // cyc holds the cycle number since accept; the element presented next cycle is index cyc.
  always_comb begin
    state_next    = state;
    cyc_next      = cyc + CW'(1);
    base_next     = base_r;
    vec_next      = vec_r;
    shadow_next   = shadow;
    vec_out_next  = vec_out;
    ram_data_next = ram_data;
    rd_addr_next  = ram_read_addr;
    wr_addr_next  = ram_write_addr;

    // Lane i returns RAM_LAT cycles after its address was presented in cycle i+1.
    if (state == LOAD_ISSUE || state == LOAD_DRAIN) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (int'(cyc) == int'(l) + 1 + RAM_LAT)
          shadow_next[8*l +: 8] = ram_q;
      end
    end

    case (state)
      IDLE: begin
        cyc_next = '0;
        if (start) begin
          cyc_next  = CW'(1);
          base_next = base_addr;
          vec_next  = vec_in;
          if (op) begin
            state_next    = STORE;
            wr_addr_next  = base_addr;
            ram_data_next = vec_in[7:0];
          end else begin
            state_next   = LOAD_ISSUE;
            rd_addr_next = base_addr;
          end
        end
      end
      STORE: begin
        if (cyc == CW'(LANES)) begin
          state_next = DONE;
        end else begin
          wr_addr_next = base_r + 6'(cyc);
          for (int unsigned l = 0; l < LANES; l++) begin
            if (int'(cyc) == int'(l))
              ram_data_next = vec_r[8*l +: 8];
          end
        end
      end
      LOAD_ISSUE: begin
        if (cyc == CW'(LANES)) begin
          if (RAM_LAT == 0) begin
            state_next   = DONE;
            vec_out_next = shadow_next;
          end else begin
            state_next = LOAD_DRAIN;
          end
        end else begin
          rd_addr_next = base_r + 6'(cyc);
        end
      end
      LOAD_DRAIN: begin
        if (cyc == CW'(LANES + RAM_LAT)) begin
          state_next   = DONE;
          vec_out_next = shadow_next;
        end
      end
      DONE: begin
        state_next = IDLE;
        cyc_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cyc_next   = '0;
      end
    endcase

    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
    we_next   = (state_next == STORE);
  end

endmodule
